// File: rtl/reg_status_file.sv
// rtl/reg_status_file.sv - register status file with rename tags, CDB resolve and registered read ports
module reg_status_file #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 3,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int CW      = $clog2(NUM_REGS + 1)
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_reg,
    input  logic [TAG_W-1:0]  iss_tag,
    input  logic [DATA_W-1:0] iss_data,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    input  logic [AW-1:0]     rd0_reg,
    input  logic [AW-1:0]     rd1_reg,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic [TAG_W-1:0]  rd0_tag,
    output logic [TAG_W-1:0]  rd1_tag,
    output logic [CW-1:0]     pend_cnt
);

    logic [DATA_W-1:0] data_q [NUM_REGS];
    logic [DATA_W-1:0] data_d [NUM_REGS];
    logic [TAG_W-1:0]  tag_q  [NUM_REGS];
    logic [TAG_W-1:0]  tag_d  [NUM_REGS];

    logic [DATA_W-1:0] rd0_data_q, rd1_data_q;
    logic [TAG_W-1:0]  rd0_tag_q, rd1_tag_q;
    logic [CW-1:0]     pend_cnt_q, pend_cnt_d;

    logic iss_ok;

    // Issues to a hardwired zero register are dropped entirely.
    always_comb begin
        iss_ok = iss_en;
        if (ZERO_REG != 0 && iss_reg == '0) begin
            iss_ok = 1'b0;
        end
    end

    // Next state: flush clears tags, CDB resolves matches against the old tags, issue overrides last.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            data_d[i] = data_q[i];
            tag_d[i]  = tag_q[i];
        end
        if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_d[i] = '0;
            end
        end
        if (cdb_valid && cdb_tag != '0) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (tag_q[i] == cdb_tag) begin
                    data_d[i] = cdb_data;
                    tag_d[i]  = '0;
                end
            end
        end
        if (iss_ok) begin
            if (iss_tag != '0) begin
                // A rename keeps the pre-cycle data even if the CDB hit this register now.
                data_d[iss_reg] = data_q[iss_reg];
                tag_d[iss_reg]  = iss_tag;
            end else begin
                data_d[iss_reg] = iss_data;
                tag_d[iss_reg]  = '0;
            end
        end
        if (ZERO_REG != 0) begin
            data_d[0] = '0;
            tag_d[0]  = '0;
        end
    end

    // Count pending registers in the next state so the count tracks the same edge.
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (tag_d[i] != '0) begin
                pend_cnt_d = pend_cnt_d + CW'(1);
            end
        end
    end

    // State and write-through read registers; reset wipes everything including pending tags.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            rd0_data_q <= '0;
            rd1_data_q <= '0;
            rd0_tag_q  <= '0;
            rd1_tag_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
            rd0_data_q <= data_d[rd0_reg];
            rd1_data_q <= data_d[rd1_reg];
            rd0_tag_q  <= tag_d[rd0_reg];
            rd1_tag_q  <= tag_d[rd1_reg];
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign rd0_data = rd0_data_q;
    assign rd1_data = rd1_data_q;
    assign rd0_tag  = rd0_tag_q;
    assign rd1_tag  = rd1_tag_q;
    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_reg_status_file.sv
// tb/tb_reg_status_file.sv - directed self-checking bench for reg_status_file
module tb_reg_status_file;

    logic        CLK;
    logic        CLR;
    logic        iss_en;
    logic [2:0]  iss_reg;
    logic [2:0]  iss_tag;
    logic [15:0] iss_data;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        flush;
    logic [2:0]  rd0_reg, rd1_reg;

    logic [15:0] rd0_data, rd1_data, z_rd0_data, z_rd1_data;
    logic [2:0]  rd0_tag, rd1_tag, z_rd0_tag, z_rd1_tag;
    logic [3:0]  pend_cnt, z_pend_cnt;

    int checks;
    int failures;

    reg_status_file #(.NUM_REGS(8), .DATA_W(16), .TAG_W(3), .ZERO_REG(0)) dut (
        .CLK(CLK), .CLR(CLR),
        .iss_en(iss_en), .iss_reg(iss_reg), .iss_tag(iss_tag), .iss_data(iss_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .rd0_reg(rd0_reg), .rd1_reg(rd1_reg),
        .rd0_data(rd0_data), .rd1_data(rd1_data),
        .rd0_tag(rd0_tag), .rd1_tag(rd1_tag), .pend_cnt(pend_cnt)
    );

    reg_status_file #(.NUM_REGS(8), .DATA_W(16), .TAG_W(3), .ZERO_REG(1)) dut_z (
        .CLK(CLK), .CLR(CLR),
        .iss_en(iss_en), .iss_reg(iss_reg), .iss_tag(iss_tag), .iss_data(iss_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .rd0_reg(rd0_reg), .rd1_reg(rd1_reg),
        .rd0_data(z_rd0_data), .rd1_data(z_rd1_data),
        .rd0_tag(z_rd0_tag), .rd1_tag(z_rd1_tag), .pend_cnt(z_pend_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        iss_en    = 1'b0;
        iss_reg   = '0;
        iss_tag   = '0;
        iss_data  = '0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        flush     = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic issue(input logic [2:0] r, input logic [2:0] t, input logic [15:0] d);
        iss_en   = 1'b1;
        iss_reg  = r;
        iss_tag  = t;
        iss_data = d;
    endtask

    task automatic cdb(input logic [2:0] t, input logic [15:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rd0_reg = '0;
        rd1_reg = '0;
        CLR     = 1'b0;
        #2;
        chk("rst_rd0_data", rd0_data, 0);
        chk("rst_rd0_tag", rd0_tag, 0);
        chk("rst_pend", pend_cnt, 0);
        // Inputs during reset are ignored
        issue(3'd1, 3'd0, 16'hAAAA);
        @(posedge CLK);
        #1;
        chk("rst_hold_pend", pend_cnt, 0);
        chk("rst_hold_data", rd0_data, 0);
        idle();
        #2;
        CLR = 1'b1;
        @(negedge CLK);

        // Direct write with same-cycle read
        issue(3'd3, 3'd0, 16'h0003);
        rd0_reg = 3'd3;
        step();
        chk("dw_rd0_data", rd0_data, 16'h0003);
        chk("dw_rd0_tag", rd0_tag, 0);
        chk("dw_pend", pend_cnt, 0);

        // Two renames to the same tag, then one broadcast resolves both
        issue(3'd2, 3'd4, 16'h0);
        rd0_reg = 3'd2;
        step();
        chk("ren_r2_tag", rd0_tag, 4);
        chk("ren_r2_stale", rd0_data, 0);
        chk("ren_pend1", pend_cnt, 1);
        issue(3'd5, 3'd4, 16'h0);
        step();
        chk("ren_pend2", pend_cnt, 2);
        cdb(3'd4, 16'hBEEF);
        rd0_reg = 3'd2;
        rd1_reg = 3'd5;
        step();
        chk("cdb_r2_data", rd0_data, 16'hBEEF);
        chk("cdb_r2_tag", rd0_tag, 0);
        chk("cdb_r5_data", rd1_data, 16'hBEEF);
        chk("cdb_r5_tag", rd1_tag, 0);
        chk("cdb_pend0", pend_cnt, 0);

        // Issue beats a same-cycle broadcast on the same register
        issue(3'd2, 3'd4, 16'h0);
        step();
        chk("re_pend1", pend_cnt, 1);
        issue(3'd2, 3'd6, 16'h0);
        cdb(3'd4, 16'h1111);
        step();
        chk("win_r2_tag", rd0_tag, 6);
        chk("win_r2_data", rd0_data, 16'hBEEF);
        chk("win_pend", pend_cnt, 1);
        chk("win_r5_data", rd1_data, 16'hBEEF);

        // Build three pending tags, then flush
        issue(3'd7, 3'd0, 16'h7777);
        cdb(3'd6, 16'h0606);
        step();
        chk("pre_pend0", pend_cnt, 0);
        chk("pre_r2_data", rd0_data, 16'h0606);
        issue(3'd1, 3'd1, 16'h0);
        step();
        issue(3'd4, 3'd2, 16'h0);
        step();
        issue(3'd7, 3'd3, 16'h0);
        rd0_reg = 3'd7;
        rd1_reg = 3'd1;
        step();
        chk("fl_pre_pend3", pend_cnt, 3);
        chk("fl_pre_r7_tag", rd0_tag, 3);
        chk("fl_pre_r7_stale", rd0_data, 16'h7777);
        flush = 1'b1;
        step();
        chk("fl_pend0", pend_cnt, 0);
        chk("fl_r7_tag", rd0_tag, 0);
        chk("fl_r7_data", rd0_data, 16'h7777);
        chk("fl_r1_tag", rd1_tag, 0);

        // Flush with same-cycle issue, then flush with same-cycle broadcast
        flush = 1'b1;
        issue(3'd4, 3'd5, 16'h0);
        rd0_reg = 3'd4;
        step();
        chk("fl_iss_tag", rd0_tag, 5);
        chk("fl_iss_pend", pend_cnt, 1);
        flush = 1'b1;
        cdb(3'd5, 16'h5555);
        step();
        chk("fl_cdb_data", rd0_data, 16'h5555);
        chk("fl_cdb_tag", rd0_tag, 0);
        chk("fl_cdb_pend", pend_cnt, 0);

        // Register 0: writable normally, hardwired in the ZERO_REG instance
        issue(3'd0, 3'd0, 16'h1234);
        rd0_reg = 3'd0;
        step();
        chk("r0_dw_data", rd0_data, 16'h1234);
        chk("z_r0_dw_data", z_rd0_data, 0);
        issue(3'd0, 3'd2, 16'h0);
        step();
        chk("r0_ren_tag", rd0_tag, 2);
        chk("r0_ren_pend", pend_cnt, 1);
        chk("z_r0_ren_data", z_rd0_data, 0);
        chk("z_r0_ren_tag", z_rd0_tag, 0);
        chk("z_r0_ren_pend", z_pend_cnt, 0);

        // Asynchronous reset between edges with work pending
        cdb(3'd2, 16'h0);
        issue(3'd1, 3'd1, 16'h0);
        step();
        issue(3'd3, 3'd3, 16'h0);
        step();
        chk("ar_pre_pend", pend_cnt, 2);
        #2;
        CLR = 1'b0;
        #1;
        chk("ar_pend", pend_cnt, 0);
        chk("ar_rd0_data", rd0_data, 0);
        chk("ar_rd0_tag", rd0_tag, 0);
        cdb(3'd3, 16'hDEAD);
        #3;
        CLR = 1'b1;
        idle();
        rd0_reg = 3'd3;
        rd1_reg = 3'd7;
        step();
        chk("ar_post_r3_data", rd0_data, 0);
        chk("ar_post_r3_tag", rd0_tag, 0);
        chk("ar_post_r7_data", rd1_data, 0);
        chk("ar_post_pend", pend_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
